// File: rtl/pipe_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid
// Description : Two-entry registered pipeline stage (skid buffer) with a
//               valid/ready handshake on both sides. in_ready, out_valid,
//               out_data and count are all driven from flops only, so no
//               combinational path crosses the stage in either direction.
//               A synchronous flush discards every held entry.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      payload width in bits (>= 1)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   flush      synchronous clear of all held entries (highest priority)
//   in_valid   upstream offers in_data
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload at the head of the stage
//   count      number of held entries (0, 1 or 2)
// ============================================================================
module pipe_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  main_q;
    logic [WIDTH-1:0]  skid_q;

    // Data-path load enables produced by the next-state logic.
    logic              load_main_in;    // main <= in_data
    logic              load_main_skid;  // main <= skid
    logic              load_skid_in;    // skid <= in_data

    logic              in_fire;
    logic              out_fire;

    // ------------------------------------------------------------------
    // Output decode: a function of the state register only.
    // ------------------------------------------------------------------
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign count     = state_q;
    assign out_data  = main_q;

    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load-enable logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;

        if (flush) begin
            // Any in_fire this cycle is dropped; an out_fire has already
            // been consumed downstream. Data registers keep their content,
            // they are simply no longer marked valid.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    // in_ready is 1 here, so in_valid alone is an in_fire.
                    if (in_valid) begin
                        load_main_in = 1'b1;
                        state_d      = BUSY;
                    end
                end

                BUSY: begin
                    if (in_fire && out_fire) begin
                        // Head leaves while the new payload replaces it.
                        load_main_in = 1'b1;
                        state_d      = BUSY;
                    end else if (in_fire) begin
                        // Head is stalled: park the new payload behind it.
                        load_skid_in = 1'b1;
                        state_d      = FULL;
                    end else if (out_fire) begin
                        state_d      = EMPTY;
                    end
                end

                FULL: begin
                    // in_ready is 0, so nothing is taken from upstream; the
                    // skid entry moves up behind the departing head.
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end

                default: begin
                    // Unreachable encoding (count = 3): recover to empty.
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload registers: written only on the enabled transitions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
        end else if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q <= '0;
        end else if (load_skid_in) begin
            skid_q <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid
// Description : Self-checking bench for pipe_skid. A queue holds the payloads
//               the stage should currently contain; payloads are pushed when
//               the bench drives an accepted transfer and popped when the
//               head is consumed, and every cycle the DUT outputs are
//               compared against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_skid #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the expected occupancy held in the queue.
    task automatic check_outputs(input string ph);
        int n;
        n = sb.size();
        chk({ph, ":out_valid"}, W'(out_valid), W'(n != 0));
        chk({ph, ":in_ready"},  W'(in_ready),  W'(n < 2));
        chk({ph, ":count"},     W'(count),     W'(n));
        if (n != 0)
            chk({ph, ":out_data"}, out_data, sb[0]);
    endtask

    // One cycle: check outputs at the falling edge, drive the new inputs,
    // and advance the expected contents to what the next rising edge does.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input string ph);
        bit ifire;
        bit ofire;
        @(negedge clk);
        check_outputs(ph);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        ifire = iv && (sb.size() < 2);
        ofire = (sb.size() > 0) && ordy;
        if (ofire)
            void'(sb.pop_front());
        if (fl)
            sb.delete();
        else if (ifire)
            sb.push_back(d);
    endtask

    initial begin
        // ---------------- reset held with in_valid asserted ----------------
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst:out_valid", W'(out_valid), '0);
            chk("rst:in_ready",  W'(in_ready),  W'(1));
            chk("rst:count",     W'(count),     '0);
            chk("rst:out_data",  out_data,      '0);
        end
        reset = 1'b1;
        #1;
        chk("release:count", W'(count), '0);
        // First rising edge after release captures the pending payload.
        sb.push_back(32'h1234_5678);

        // ---------------- streaming ----------------
        step(1'b1, 32'h1111_1111, 1'b1, 1'b0, "stream");
        step(1'b1, 32'h2222_2222, 1'b1, 1'b0, "stream");
        step(1'b1, 32'h3333_3333, 1'b1, 1'b0, "stream");
        step(1'b0, 32'h0,         1'b1, 1'b0, "stream");
        step(1'b0, 32'h0,         1'b1, 1'b0, "stream_end");

        // ---------------- back-pressure ----------------
        step(1'b1, 32'hA0, 1'b0, 1'b0, "bp");
        step(1'b1, 32'hB0, 1'b0, 1'b0, "bp");
        step(1'b1, 32'hC0, 1'b0, 1'b0, "bp_full");
        step(1'b1, 32'hC0, 1'b0, 1'b0, "bp_stall");
        step(1'b1, 32'hC0, 1'b1, 1'b0, "bp_drain");
        step(1'b1, 32'hC0, 1'b1, 1'b0, "bp_drain");
        step(1'b0, 32'h0,  1'b1, 1'b0, "bp_drain");
        step(1'b0, 32'h0,  1'b1, 1'b0, "bp_empty");

        // ---------------- simultaneous fire in BUSY ----------------
        step(1'b1, 32'h5, 1'b0, 1'b0, "sim");
        step(1'b1, 32'h6, 1'b1, 1'b0, "sim_fire");
        step(1'b0, 32'h0, 1'b0, 1'b0, "sim_hold");
        step(1'b0, 32'h0, 1'b1, 1'b0, "sim_out");

        // ---------------- flush from FULL ----------------
        step(1'b1, 32'hA0, 1'b0, 1'b0, "fl");
        step(1'b1, 32'hB0, 1'b0, 1'b0, "fl");
        step(1'b1, 32'hD0, 1'b0, 1'b1, "fl_full");
        step(1'b0, 32'h0,  1'b1, 1'b0, "fl_after");
        step(1'b1, 32'hE0, 1'b1, 1'b0, "fl_after");
        step(1'b0, 32'h0,  1'b1, 1'b0, "fl_resume");
        step(1'b0, 32'h0,  1'b1, 1'b0, "fl_resume");

        // ---------------- flush from BUSY with out_fire ----------------
        step(1'b1, 32'hF1, 1'b0, 1'b0, "flo");
        step(1'b1, 32'hF2, 1'b1, 1'b1, "flo_busy");
        step(1'b0, 32'h0,  1'b1, 1'b0, "flo_after");

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, "rand");
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "rand_drain");
        step(1'b0, 32'h0, 1'b1, 1'b0, "rand_drain");

        // ---------------- async reset mid-stall ----------------
        step(1'b1, 32'hA1, 1'b0, 1'b0, "ar");
        step(1'b1, 32'hB1, 1'b0, 1'b0, "ar");
        step(1'b0, 32'h0,  1'b0, 1'b0, "ar_full");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("ar:out_valid", W'(out_valid), '0);
        chk("ar:in_ready",  W'(in_ready),  W'(1));
        chk("ar:count",     W'(count),     '0);
        chk("ar:out_data",  out_data,      '0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'h77, 1'b0, 1'b0, "ar_after");
        step(1'b0, 32'h0,  1'b1, 1'b0, "ar_after");
        step(1'b0, 32'h0,  1'b1, 1'b0, "ar_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid.md
# pipe_skid

Two-entry registered pipeline stage with a valid/ready handshake on both sides. It is the receiving end of one stage's output and the sending end into the next. It cuts every combinational path through the handshake: `in_ready` and all outputs come from flops only. It sits between core pipeline stages (for example fetch to decode), loses no data under back-pressure, and supports a synchronous flush for branch or exception redirect.

## Interface
- WIDTH, 32, payload width in bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous clear; discards all held entries.
- in_valid  in  1  upstream has a payload on in_data.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload at the head of the stage.
- count  out  2  number of held entries (0, 1 or 2).

## Operation
- Storage: main register (head, drives out_data) and skid register (second entry).
- Transfers:
  - Input transfer (in_fire) = in_valid & in_ready.
  - Output transfer (out_fire) = out_valid & out_ready.
- States: EMPTY (count 0), BUSY (count 1), FULL (count 2).
- Outputs by state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - count = state encoding.
  - All are decoded from the state register only; nothing is combinational from in_valid or out_ready.
- Transitions (flush clear):
  - EMPTY, in_valid: main <= in_data, go to BUSY.
  - EMPTY, no in_valid: stay in EMPTY.
  - BUSY, in_fire & out_fire: main <= in_data, stay in BUSY.
  - BUSY, in_fire only: skid <= in_data, go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_ready: main <= skid, go to BUSY. in_ready is 0, so no input is taken.
  - FULL, no out_ready: hold.
- Flush:
  - Highest priority: next state is EMPTY whatever the handshakes.
  - An in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle still counts as consumed by downstream.
  - Data registers are not cleared by flush; only the state is.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Data in main and skid is not written except on the transitions above.
- Payload is passed through unmodified, bit-exact for any WIDTH ≥ 1.
- Illegal state encoding (count = 3): go to EMPTY on the next clock.

## Timing
- Reset (reset = 0, asynchronous):
  - State is EMPTY, so out_valid = 0, in_ready = 1 and count = 0.
  - Main and skid registers are 0, so out_data = 0.
- Reset release: the first accepting edge is the first rising clk with reset = 1.
- Latency: a payload accepted at edge N is on out_data with out_valid = 1 after edge N, i.e. in cycle N+1. There is no combinational bypass.
- Throughput: one transfer per cycle sustained while out_ready = 1.
- Back-pressure:
  - When out_ready drops, at most one extra payload is absorbed (into skid).
  - in_ready falls in the cycle after that capture.
- Stall hold: out_valid and out_data remain stable while out_valid = 1 and out_ready = 0.
- Reset mid-operation: held entries are lost, outputs return to reset values immediately, and no partial transfer completes.

## Test plan
- Reset: hold reset = 0 with in_valid = 1, then release. Required: out_valid = 0, in_ready = 1, count = 0, out_data = 0 throughout reset, and no capture until the first edge after release.
- Streaming: out_ready = 1; send 0x11111111, 0x22222222 and 0x33333333 on consecutive cycles. Required: each appears on out_data one cycle after its acceptance, in order, with no bubbles and count = 1 throughout.
- Back-pressure:
  - From EMPTY, out_ready = 0; offer 0xA0, 0xB0, 0xC0 on consecutive cycles.
  - Required: 0xA0 and 0xB0 are accepted, in_ready = 0 while 0xC0 is held, and count = 2.
  - Then set out_ready = 1. Required: outputs in order 0xA0, 0xB0, 0xC0, with 0xC0 accepted once in_ready returns.
- Simultaneous fire: in BUSY holding 0x5, in_valid = 1 with 0x6 and out_ready = 1. Required: 0x5 is consumed, main = 0x6, and the state stays BUSY.
- Flush:
  - In FULL (0xA0, 0xB0), assert flush for one cycle with in_valid = 1 and in_data 0xD0.
  - Required: next cycle out_valid = 0, count = 0, in_ready = 1, and 0xD0 never appears on out_data.
- Async reset mid-stall: in FULL, pull reset low between clock edges. Required: out_valid = 0, in_ready = 1 and out_data = 0 immediately, without waiting for clk.
